// File: rtl/calc_pkg.sv
// calc_pkg: op codes and sequencer state encoding shared by the calculator blocks
package calc_pkg;
  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_ABS_A  = 3'b110;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
endpackage

// File: rtl/calc_alu4.sv
// calc_alu4: combinational 4-bit signed add/sub/abs with two's-complement overflow
module calc_alu4 (
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] res,
  output logic       ovf
);
  logic [3:0] x, y, s, d, m;
  // op[2] swaps operand roles: B+A, B-A and |A| reuse the A-first datapath
  assign x = op[2] ? b : a;
  assign y = op[2] ? a : b;
  assign s = x + y;
  assign d = x - y;
  assign m = y[3] ? 4'd0 - y : y;
  always_comb begin
    res = op[1] ? m : op[0] ? d : s;
    ovf = op[1] ? (y == 4'b1000)
        : op[0] ? (x[3] != y[3] && d[3] != x[3])
        : (x[3] == y[3] && s[3] != x[3]);
  end
endmodule

// File: rtl/calc_alu_arbiter.sv
// calc_alu_arbiter: round-robin two-requester sequencer for the shared calc_alu4,
// holding the registered result until the winner acknowledges
module calc_alu_arbiter
  import calc_pkg::*;
#(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [2:0]           op0,
  input  logic [2:0]           op1,
  input  logic [3:0]           a0,
  input  logic [3:0]           a1,
  input  logic [3:0]           b0,
  input  logic [3:0]           b1,
  input  logic [1:0]           ack,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [3:0]           res,
  output logic                 ovf,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);
  state_t     state;
  logic       rr, win, sel, alu_ovf;
  logic [2:0] op_r;
  logic [3:0] a_r, b_r, alu_res;
  assign sel = &req ? rr : req[1];
  calc_alu4 u_alu (.op(op_r), .a(a_r), .b(b_r), .res(alu_res), .ovf(alu_ovf));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr      <= 1'b0;
      win     <= 1'b0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      gnt     <= '0;
      done    <= '0;
      res     <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: if (|req) begin
          win   <= sel;
          op_r  <= sel ? op1 : op0;
          a_r   <= sel ? a1 : a0;
          b_r   <= sel ? b1 : b0;
          gnt   <= 2'b01 << sel;
          busy  <= 1'b1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          res   <= alu_res;
          ovf   <= alu_ovf;
          done  <= 2'b01 << win;
          if (alu_ovf && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
          state <= ST_DONE;
        end
        ST_DONE: if (ack[win]) begin
          done  <= '0;
          rr    <= ~win;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_alu_arbiter.sv
// tb_calc_alu_arbiter: randomized self-checking bench against an integer-arithmetic reference
module tb_calc_alu_arbiter;
  localparam int W = 8;
  localparam int CNT_MAX = (1 << W) - 1;
  logic         clk = 0, rst = 1;
  logic [1:0]   req = 0, ack = 0;
  logic [2:0]   op0 = 0, op1 = 0;
  logic [3:0]   a0 = 0, a1 = 0, b0 = 0, b1 = 0;
  logic [1:0]   gnt, done;
  logic [3:0]   res;
  logic         ovf, busy;
  logic [W-1:0] ovf_cnt;
  int checks = 0, failures = 0;
  int m_rr = 0, m_cnt = 0;
  logic [3:0] last_res;
  logic       last_ovf;

  calc_alu_arbiter #(.OVF_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1), .a0(a0), .a1(a1),
    .b0(b0), .b1(b1), .ack(ack), .gnt(gnt), .done(done), .res(res), .ovf(ovf),
    .busy(busy), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_alu(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (o[1]) v = o[2] ? (sa < 0 ? -sa : sa) : (sb < 0 ? -sb : sb);
    else if (o[0]) v = o[2] ? sb - sa : sa - sb;
    else v = sa + sb;
    return {(v > 7 || v < -8), v[3:0]};
  endfunction

  task automatic txn(input logic [1:0] r, input logic [2:0] o0v, input logic [3:0] a0v, input logic [3:0] b0v,
                     input logic [2:0] o1v, input logic [3:0] a1v, input logic [3:0] b1v, input bit wrong_ack);
    int w;
    logic [4:0] e;
    req = r; op0 = o0v; a0 = a0v; b0 = b0v; op1 = o1v; a1 = a1v; b1 = b1v; ack = 0;
    w = (r == 2'b11) ? m_rr : (r[1] ? 1 : 0);
    e = w ? ref_alu(o1v, a1v, b1v) : ref_alu(o0v, a0v, b0v);
    @(posedge clk); #1;
    chk("gnt", gnt, 32'(2'b01 << w));
    chk("busy_gnt", busy, 1);
    chk("done_gnt", done, 0);
    req[w] = 1'($urandom);
    op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
    op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    @(posedge clk); #1;
    if (e[4] && m_cnt != CNT_MAX) m_cnt++;
    chk("gnt_pulse", gnt, 0);
    chk("done", done, 32'(2'b01 << w));
    chk("res", res, e[3:0]);
    chk("ovf", ovf, e[4]);
    chk("ovf_cnt", ovf_cnt, m_cnt);
    if (wrong_ack) begin
      ack = 2'b01 << (1 - w);
      @(posedge clk); #1;
      chk("hold_done", done, 32'(2'b01 << w));
      chk("hold_res", res, e[3:0]);
      chk("hold_busy", busy, 1);
    end
    ack = 2'b01 << w;
    @(posedge clk); #1;
    ack = 0;
    req = 0;
    m_rr = 1 - w;
    chk("done_ack", done, 0);
    chk("busy_ack", busy, 0);
    chk("res_kept", res, e[3:0]);
    last_res = e[3:0];
    last_ovf = e[4];
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_res", res, 0);
    chk("rst_ovf", ovf, 0); chk("rst_busy", busy, 0); chk("rst_cnt", ovf_cnt, 0);
    rst = 0;
    txn(2'b01, 3'b000, 4'b0100, 4'b0011, 3'b000, 4'b0000, 4'b0000, 0);
    txn(2'b11, 3'b000, 4'b0111, 4'b0001, 3'b001, 4'b1001, 4'b0111, 0);
    txn(2'b11, 3'b010, 4'b0000, 4'b1000, 3'b110, 4'b1100, 4'b0000, 1);
    txn(2'b10, 3'b000, 4'b0000, 4'b0000, 3'b101, 4'b1000, 4'b1000, 1);
    txn(2'b01, 3'b110, 4'b1100, 4'b0000, 3'b000, 4'b0000, 4'b0000, 0);
    txn(2'b01, 3'b100, 4'b1000, 4'b1111, 3'b000, 4'b0000, 4'b0000, 0);
    // reset in EXEC: outputs clear asynchronously and the transaction never completes
    req = 2'b01; op0 = 3'b000; a0 = 4'b0111; b0 = 4'b0111;
    @(posedge clk); #1;
    chk("pre_rst_gnt", gnt, 1);
    #2 rst = 1; #1;
    chk("arst_gnt", gnt, 0); chk("arst_done", done, 0); chk("arst_res", res, 0);
    chk("arst_ovf", ovf, 0); chk("arst_busy", busy, 0); chk("arst_cnt", ovf_cnt, 0);
    req = 0;
    @(negedge clk) rst = 0;
    m_rr = 0; m_cnt = 0;
    @(posedge clk); #1;
    chk("no_done_after_rst", done, 0);
    txn(2'b11, 3'b001, 4'b0001, 4'b0001, 3'b000, 4'b0001, 4'b0001, 0);
    for (int i = 0; i < CNT_MAX + 2; i++)
      txn(2'($urandom_range(1, 3)), 3'b010, 4'b0000, 4'b1000, 3'b110, 4'b1000, 4'b0000, 0);
    chk("cnt_sat", ovf_cnt, CNT_MAX);
    for (int i = 0; i < 300; i++)
      txn(2'($urandom_range(1, 3)), 3'($urandom), 4'($urandom), 4'($urandom),
          3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    repeat (2) @(posedge clk);
    #1;
    chk("idle_res", res, last_res);
    chk("idle_ovf", ovf, last_ovf);
    chk("idle_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
